uart_mmio_bridge: RTL and testbench

- Memory-mapped I/O bridge between the ARC processor datapath and the UART core.
- Decodes processor load/store accesses to two I/O addresses (UART data, UART status) and turns them into single-cycle `rd_uart`/`wr_uart` strobes.
- Stalls the processor with a ready handshake while the UART cannot accept or supply data.
- Returns read data and drives the select used by the MM/IO read-data multiplexer; replaces the push-button/debounce strobe path in the processor-integrated system.

---
 rtl/uart_mmio_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: memory-mapped I/O bridge between the ARC processor
// load/store port and the UART core FIFOs.
//   - Decodes DATA_ADDR (pop RX / push TX) and STAT_ADDR (read-only status).
//   - Issues exactly one rd/wr strobe per processor request and completes the
//     access with a one-cycle cpu_ready pulse.
//   - Optional stall timeout, enabled by defining ARC_IO_TIMEOUT_EN.
module uart_mmio_bridge #(
    parameter logic [31:0] DATA_ADDR      = 32'hFFFF_FFF0,
    parameter logic [31:0] STAT_ADDR      = 32'hFFFF_FFF4,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        io_sel,
    output logic        uart_rd,
    output logic        uart_wr,
    output logic [7:0]  uart_wdata,
    input  logic [7:0]  uart_rdata,
    input  logic        uart_tx_full,
    input  logic        uart_rx_empty
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RX,
        S_POP,
        S_WAIT_TX,
        S_PUSH,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_req;
    logic w_hit_data;
    logic w_hit_stat;
    logic w_ld_stat;    // capture status word into cpu_rdata
    logic w_ld_rx;      // capture RX head byte into cpu_rdata
    logic w_ld_tx;      // capture store byte into uart_wdata
    logic w_cnt_clr;    // entering a wait state
    logic w_tout_hit;   // stall limit reached this cycle
    logic w_timeout;    // wait abandoned by timeout this cycle
    logic w_tout_flag;
    logic w_unused;

    // Upper store-data bits are architecturally ignored; the timeout limit is
    // only consumed when the timeout feature is compiled in.
    assign w_unused = ^{cpu_wdata[31:8], TIMEOUT_CYCLES};

    assign w_req      = cpu_rd | cpu_wr;
    assign w_hit_data = (cpu_addr == DATA_ADDR);
    assign w_hit_stat = (cpu_addr == STAT_ADDR);
    assign io_sel     = w_req & (w_hit_data | w_hit_stat);

`ifdef ARC_IO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tout_flag;

    assign w_tout_hit  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_tout_flag = r_tout_flag;

    // Stall counter: cleared on entry to a wait state, counts while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT_RX || r_state == S_WAIT_TX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky timeout flag: set on timeout, cleared by the status read that
    // reports it (the read captures the old value in the same edge).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tout_flag <= 1'b0;
        end else if (w_timeout) begin
            r_tout_flag <= 1'b1;
        end else if (w_ld_stat) begin
            r_tout_flag <= 1'b0;
        end
    end
`else
    assign w_tout_hit  = 1'b0;
    assign w_tout_flag = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        w_next    = r_state;
        w_ld_stat = 1'b0;
        w_ld_rx   = 1'b0;
        w_ld_tx   = 1'b0;
        w_cnt_clr = 1'b0;
        w_timeout = 1'b0;
        cpu_ready = 1'b0;
        uart_rd   = 1'b0;
        uart_wr   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (io_sel) begin
                    if (cpu_rd) begin
                        // A simultaneous store is ignored: reads win.
                        if (w_hit_stat) begin
                            w_ld_stat = 1'b1;
                            w_next    = S_ACK;
                        end else begin
                            w_cnt_clr = 1'b1;
                            w_next    = uart_rx_empty ? S_WAIT_RX : S_POP;
                        end
                    end else if (w_hit_data) begin
                        w_ld_tx   = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_next    = uart_tx_full ? S_WAIT_TX : S_PUSH;
                    end else begin
                        // Store to the read-only status register is dropped.
                        w_next = S_ACK;
                    end
                end
            end
            S_WAIT_RX: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else if (!uart_rx_empty) begin
                    w_next = S_POP;
                end else if (w_tout_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_ACK;
                end
            end
            S_WAIT_TX: begin
                if (!w_req) begin
                    w_next = S_IDLE;
                end else if (!uart_tx_full) begin
                    w_next = S_PUSH;
                end else if (w_tout_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_ACK;
                end
            end
            S_POP: begin
                uart_rd = 1'b1;
                w_ld_rx = 1'b1;
                w_next  = S_ACK;
            end
            S_PUSH: begin
                uart_wr = 1'b1;
                w_next  = S_ACK;
            end
            S_ACK: begin
                cpu_ready = 1'b1;
                w_next    = S_RELEASE;
            end
            S_RELEASE: begin
                // Hold off until the processor drops its request so a long
                // request cannot trigger a second strobe.
                if (!w_req) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Load-data register: status word, RX byte, or zero on a timed-out read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= '0;
        end else if (w_ld_stat) begin
            cpu_rdata <= {29'b0, w_tout_flag, uart_tx_full, uart_rx_empty};
        end else if (w_ld_rx) begin
            cpu_rdata <= {24'b0, uart_rdata};
        end else if (w_timeout) begin
            cpu_rdata <= '0;
        end
    end

    // TX byte register, captured when the store is accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_wdata <= '0;
        end else if (w_ld_tx) begin
            uart_wdata <= cpu_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed testbench for uart_mmio_bridge. Scenarios for the optional stall
// timeout run when ARC_IO_TIMEOUT_EN is defined (DUT built with a 16-cycle limit).
module tb_uart_mmio_bridge;

    localparam logic [31:0] DATA_A = 32'hFFFF_FFF0;
    localparam logic [31:0] STAT_A = 32'hFFFF_FFF4;
    localparam int          TOUT   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        io_sel;
    logic        uart_rd;
    logic        uart_wr;
    logic [7:0]  uart_wdata;
    logic [7:0]  uart_rdata = '0;
    logic        uart_tx_full = 1'b0;
    logic        uart_rx_empty = 1'b1;

    int n_chk = 0;
    int n_err = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_rdy = 0;
    int n_both = 0;

    uart_mmio_bridge #(
        .DATA_ADDR      (DATA_A),
        .STAT_ADDR      (STAT_A),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ready     (cpu_ready),
        .io_sel        (io_sel),
        .uart_rd       (uart_rd),
        .uart_wr       (uart_wr),
        .uart_wdata    (uart_wdata),
        .uart_rdata    (uart_rdata),
        .uart_tx_full  (uart_tx_full),
        .uart_rx_empty (uart_rx_empty)
    );

    always #5 clk = ~clk;

    // Strobe/ready monitor, sampled at the edge that ends each cycle.
    always @(posedge clk) begin
        if (uart_rd) n_rd++;
        if (uart_wr) n_wr++;
        if (cpu_ready) n_rdy++;
        if (uart_rd && uart_wr) n_both++;
    end

    task automatic clr_mon();
        @(negedge clk);
        n_rd = 0; n_wr = 0; n_rdy = 0;
    endtask

    // Drive one request, measure cycles to cpu_ready (request cycle = 1),
    // keep the request for `hold` extra cycles, then drop it.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int hold,
                             output int lat, output logic [31:0] data, output bit tmo);
        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
        lat = 1; tmo = 1'b1; data = '0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (cpu_ready) begin
                data = cpu_rdata; tmo = 1'b0;
                break;
            end
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if ({cpu_ready, uart_rd, uart_wr, io_sel} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl got %b exp 0000", {cpu_ready, uart_rd, uart_wr, io_sel}); end
        n_chk++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", cpu_rdata); end
        n_chk++; if (uart_wdata !== 8'h0) begin n_err++; $display("FAIL reset_wdata got %h exp 0", uart_wdata); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_status_read();
        int lat; logic [31:0] d; bit tmo;
        uart_rx_empty = 1'b1; uart_tx_full = 1'b0;
        clr_mon();
        do_access(1'b1, 1'b0, STAT_A, 32'h0, 0, lat, d, tmo);
        n_chk++; if (tmo || lat != 2) begin n_err++; $display("FAIL stat_lat got %0d (tmo %0d) exp 2", lat, tmo); end
        n_chk++; if (d !== 32'h0000_0001) begin n_err++; $display("FAIL stat_data1 got %h exp 00000001", d); end
        n_chk++; if (n_rd != 0 || n_wr != 0) begin n_err++; $display("FAIL stat_strobes got rd %0d wr %0d exp 0 0", n_rd, n_wr); end
        uart_rx_empty = 1'b0; uart_tx_full = 1'b1;
        do_access(1'b1, 1'b0, STAT_A, 32'h0, 0, lat, d, tmo);
        n_chk++; if (d !== 32'h0000_0002) begin n_err++; $display("FAIL stat_data2 got %h exp 00000002", d); end
        uart_tx_full = 1'b0; uart_rx_empty = 1'b1;
    endtask

    task automatic test_io_sel();
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = DATA_A; #1;
        n_chk++; if (io_sel !== 1'b1) begin n_err++; $display("FAIL io_sel_data got %b exp 1", io_sel); end
        cpu_rd = 1'b0; cpu_addr = STAT_A; #1;
        n_chk++; if (io_sel !== 1'b0) begin n_err++; $display("FAIL io_sel_noreq got %b exp 0", io_sel); end
        cpu_wr = 1'b1; cpu_addr = 32'hFFFF_FFF8; #1;
        n_chk++; if (io_sel !== 1'b0) begin n_err++; $display("FAIL io_sel_miss got %b exp 0", io_sel); end
        cpu_wr = 1'b0;
    endtask

    task automatic test_nonmatch();
        clr_mon();
        cpu_rd = 1'b1; cpu_addr = 32'h0000_1000;
        repeat (6) @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'hFFFF_FFFC;
        repeat (6) @(negedge clk);
        cpu_wr = 1'b0;
        @(negedge clk);
        n_chk++; if (n_rdy != 0 || n_rd != 0 || n_wr != 0) begin n_err++; $display("FAIL nonmatch got rdy %0d rd %0d wr %0d exp 0 0 0", n_rdy, n_rd, n_wr); end
    endtask

    task automatic test_data_read();
        int lat; logic [31:0] d; bit tmo;
        logic [7:0] vals [2] = '{8'h41, 8'hA5};
        uart_rx_empty = 1'b0;
        foreach (vals[k]) begin
            uart_rdata = vals[k];
            clr_mon();
            do_access(1'b1, 1'b0, DATA_A, 32'h0, 0, lat, d, tmo);
            n_chk++; if (tmo || lat != 3) begin n_err++; $display("FAIL rd_lat got %0d (tmo %0d) exp 3", lat, tmo); end
            n_chk++; if (d !== {24'h0, vals[k]}) begin n_err++; $display("FAIL rd_data got %h exp %h", d, {24'h0, vals[k]}); end
            n_chk++; if (n_rd != 1 || n_wr != 0) begin n_err++; $display("FAIL rd_strobes got rd %0d wr %0d exp 1 0", n_rd, n_wr); end
        end
        uart_rx_empty = 1'b1;
    endtask

    task automatic test_data_write();
        int lat; logic [31:0] d; bit tmo;
        clr_mon();
        do_access(1'b0, 1'b1, DATA_A, 32'h1234_5678, 0, lat, d, tmo);
        n_chk++; if (tmo || lat != 3) begin n_err++; $display("FAIL wr_lat got %0d (tmo %0d) exp 3", lat, tmo); end
        n_chk++; if (uart_wdata !== 8'h78) begin n_err++; $display("FAIL wr_byte got %h exp 78", uart_wdata); end
        n_chk++; if (n_wr != 1 || n_rd != 0) begin n_err++; $display("FAIL wr_strobes got rd %0d wr %0d exp 0 1", n_rd, n_wr); end
        clr_mon();
        do_access(1'b0, 1'b1, STAT_A, 32'h0000_00FF, 0, lat, d, tmo);
        n_chk++; if (tmo || lat != 2) begin n_err++; $display("FAIL statwr_lat got %0d (tmo %0d) exp 2", lat, tmo); end
        n_chk++; if (n_wr != 0 || n_rd != 0 || uart_wdata !== 8'h78) begin n_err++; $display("FAIL statwr_side got rd %0d wr %0d byte %h exp 0 0 78", n_rd, n_wr, uart_wdata); end
    endtask

    task automatic test_write_stall();
        int bad = 0;
        uart_tx_full = 1'b1;
        clr_mon();
        cpu_wr = 1'b1; cpu_addr = DATA_A; cpu_wdata = 32'h0000_0052;
        repeat (10) begin
            @(posedge clk); #1;
            if (uart_wr || cpu_ready) bad++;
        end
        n_chk++; if (bad != 0) begin n_err++; $display("FAIL stall_quiet got %0d active cycles exp 0", bad); end
        @(negedge clk); uart_tx_full = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h52) begin n_err++; $display("FAIL stall_push got wr %b byte %h exp 1 52", uart_wr, uart_wdata); end
        @(posedge clk); #1;
        n_chk++; if (cpu_ready !== 1'b1 || uart_wr !== 1'b0) begin n_err++; $display("FAIL stall_ack got rdy %b wr %b exp 1 0", cpu_ready, uart_wr); end
        @(negedge clk); cpu_wr = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (n_wr != 1) begin n_err++; $display("FAIL stall_count got %0d exp 1", n_wr); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] d; bit tmo;
        uart_rx_empty = 1'b0; uart_tx_full = 1'b0; uart_rdata = 8'h3C;
        clr_mon();
        do_access(1'b1, 1'b1, DATA_A, 32'h0000_0099, 20, lat, d, tmo);
        n_chk++; if (tmo || d !== 32'h0000_003C) begin n_err++; $display("FAIL held_data got %h (tmo %0d) exp 0000003c", d, tmo); end
        n_chk++; if (n_rd != 1 || n_wr != 0 || n_rdy != 1) begin n_err++; $display("FAIL held_once got rd %0d wr %0d rdy %0d exp 1 0 1", n_rd, n_wr, n_rdy); end
        // Two back-to-back accesses after the held one.
        clr_mon();
        do_access(1'b1, 1'b0, DATA_A, 32'h0, 0, lat, d, tmo);
        do_access(1'b0, 1'b1, DATA_A, 32'h0000_00C3, 0, lat, d, tmo);
        n_chk++; if (n_rd != 1 || n_wr != 1 || n_rdy != 2 || uart_wdata !== 8'hC3) begin n_err++; $display("FAIL b2b got rd %0d wr %0d rdy %0d byte %h exp 1 1 2 c3", n_rd, n_wr, n_rdy, uart_wdata); end
        uart_rx_empty = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        uart_tx_full = 1'b1;
        clr_mon();
        cpu_wr = 1'b1; cpu_addr = DATA_A; cpu_wdata = 32'h0000_0033;
        repeat (4) @(negedge clk);
        rst = 1'b0; #1;
        n_chk++; if ({cpu_ready, uart_rd, uart_wr} !== 3'b000 || uart_wdata !== 8'h0 || cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rstwait_async got ctl %b byte %h data %h exp 000 00 0", {cpu_ready, uart_rd, uart_wr}, uart_wdata, cpu_rdata); end
        cpu_wr = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); uart_tx_full = 1'b0;
        repeat (10) @(negedge clk);
        n_chk++; if (n_wr != 0 || n_rdy != 0 || uart_wdata !== 8'h0) begin n_err++; $display("FAIL rstwait_quiet got wr %0d rdy %0d byte %h exp 0 0 00", n_wr, n_rdy, uart_wdata); end
    endtask

    task automatic test_drop_mid_wait();
        uart_rx_empty = 1'b1; uart_rdata = 8'h77;
        clr_mon();
        cpu_rd = 1'b1; cpu_addr = DATA_A;
        repeat (8) @(negedge clk);
        cpu_rd = 1'b0;
        @(negedge clk); uart_rx_empty = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++; if (n_rd != 0 || n_rdy != 0) begin n_err++; $display("FAIL drop_wait got rd %0d rdy %0d exp 0 0", n_rd, n_rdy); end
        uart_rx_empty = 1'b1;
    endtask

`ifdef ARC_IO_TIMEOUT_EN
    task automatic test_timeout();
        int lat; logic [31:0] d; bit tmo;
        uart_rx_empty = 1'b1; uart_tx_full = 1'b0;
        do_access(1'b1, 1'b0, STAT_A, 32'h0, 0, lat, d, tmo);   // leaves cpu_rdata = 1
        clr_mon();
        do_access(1'b1, 1'b0, DATA_A, 32'h0, 0, lat, d, tmo);
        n_chk++; if (tmo || lat < TOUT + 1 || lat > TOUT + 4) begin n_err++; $display("FAIL tout_lat got %0d (tmo %0d) exp %0d..%0d", lat, tmo, TOUT + 1, TOUT + 4); end
        n_chk++; if (d !== 32'h0 || n_rd != 0) begin n_err++; $display("FAIL tout_data got %h rd %0d exp 0 0", d, n_rd); end
        do_access(1'b1, 1'b0, STAT_A, 32'h0, 0, lat, d, tmo);
        n_chk++; if (d !== 32'h0000_0005) begin n_err++; $display("FAIL tout_flag_set got %h exp 00000005", d); end
        do_access(1'b1, 1'b0, STAT_A, 32'h0, 0, lat, d, tmo);
        n_chk++; if (d !== 32'h0000_0001) begin n_err++; $display("FAIL tout_flag_clr got %h exp 00000001", d); end
    endtask
`else
    task automatic test_unbounded_wait();
        int lat; logic [31:0] d; bit tmo;
        uart_rx_empty = 1'b1;
        clr_mon();
        cpu_rd = 1'b1; cpu_addr = DATA_A;
        repeat (200) @(negedge clk);
        cpu_rd = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (n_rdy != 0 || n_rd != 0) begin n_err++; $display("FAIL unbounded got rdy %0d rd %0d exp 0 0", n_rdy, n_rd); end
        do_access(1'b1, 1'b0, STAT_A, 32'h0, 0, lat, d, tmo);
        n_chk++; if (d !== 32'h0000_0001) begin n_err++; $display("FAIL no_flag got %h exp 00000001", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_status_read();
        test_io_sel();
        test_nonmatch();
        test_data_read();
        test_data_write();
        test_write_stall();
        test_back_to_back();
        test_reset_mid_wait();
        test_drop_mid_wait();
`ifdef ARC_IO_TIMEOUT_EN
        test_timeout();
`else
        test_unbounded_wait();
`endif
        n_chk++; if (n_both != 0) begin n_err++; $display("FAIL dual_strobe got %0d cycles exp 0", n_both); end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
